// File: rtl/cnn_icb_scratchpad.sv
// ICB slave scratchpad SRAM with in-order response FIFO and access-error flagging.
// Optional statistics counters are enabled by defining CNN_SCRATCH_STATS_EN.
module cnn_icb_scratchpad #(
   parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
   parameter int          DEPTH_WORDS    = 1024,
   parameter int          RSP_FIFO_DEPTH = 2
) (
   input  logic        nice_clk,
   input  logic        rst,
   input  logic        icb_cmd_valid,
   output logic        icb_cmd_ready,
   input  logic [31:0] icb_cmd_addr,
   input  logic        icb_cmd_read,
   input  logic [31:0] icb_cmd_wdata,
   input  logic [1:0]  icb_cmd_size,
   output logic        icb_rsp_valid,
   input  logic        icb_rsp_ready,
   output logic [31:0] icb_rsp_rdata,
   output logic        icb_rsp_err
`ifdef CNN_SCRATCH_STATS_EN
   ,
   input  logic        stat_clr,
   output logic [15:0] stat_rd_cnt,
   output logic [15:0] stat_wr_cnt,
   output logic [15:0] stat_err_cnt
`endif
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int PW = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;
   localparam int CW = $clog2(RSP_FIFO_DEPTH + 1);

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   // ------------------------------------------------------------------
   // Command decode
   // ------------------------------------------------------------------
   logic [31:0]   off;
   logic          below, above, misalign, cmd_err;
   logic [AW-1:0] widx;
   logic [3:0]    be;
   logic          accept, pop, we;

   // BASE_ADDR is word aligned, so off[1:0] equals the lane bits of the address.
   assign off   = icb_cmd_addr - BASE_ADDR;
   assign below = icb_cmd_addr < BASE_ADDR;
   assign above = |off[31:AW+2];
   assign widx  = off[AW+1:2];

   always_comb begin
      misalign = 1'b0;
      be       = 4'b0000;
      case (icb_cmd_size)
         2'd0: be = 4'b0001 << off[1:0];
         2'd1: begin
            misalign = off[0];
            be       = off[1] ? 4'b1100 : 4'b0011;
         end
         2'd2: begin
            misalign = |off[1:0];
            be       = 4'b1111;
         end
         default: misalign = 1'b1;
      endcase
   end

   assign cmd_err = below | above | misalign;
   assign accept  = icb_cmd_valid & icb_cmd_ready;
   assign we      = accept & ~icb_cmd_read & ~cmd_err;

   // ------------------------------------------------------------------
   // Storage array (not reset)
   // ------------------------------------------------------------------
   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge nice_clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[widx][8*i +: 8] <= icb_cmd_wdata[8*i +: 8];
         end
      end
   end

   rsp_t push_rsp;

   always_comb begin
      push_rsp.err   = cmd_err;
      push_rsp.rdata = (icb_cmd_read && !cmd_err) ? mem[widx] : 32'h0;
   end

   // ------------------------------------------------------------------
   // Response FIFO
   // ------------------------------------------------------------------
   rsp_t          fifo [RSP_FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   rsp_t          head;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(RSP_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign icb_cmd_ready = (count < CW'(RSP_FIFO_DEPTH));
   assign icb_rsp_valid = (count != '0);
   assign pop           = icb_rsp_valid & icb_rsp_ready;
   assign head          = fifo[rd_ptr];
   // Gating by valid keeps the outputs at zero after reset without resetting storage.
   assign icb_rsp_rdata = icb_rsp_valid ? head.rdata : 32'h0;
   assign icb_rsp_err   = icb_rsp_valid & head.err;

   always_ff @(posedge nice_clk) begin
      if (accept) fifo[wr_ptr] <= push_rsp;
   end

   always_ff @(posedge nice_clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)    rd_ptr <= ptr_inc(rd_ptr);
         case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef CNN_SCRATCH_STATS_EN
   // ------------------------------------------------------------------
   // Saturating statistics; clear has priority over increment
   // ------------------------------------------------------------------
   logic inc_rd, inc_wr, inc_err;

   assign inc_rd  = accept &  icb_cmd_read & ~cmd_err;
   assign inc_wr  = we;
   assign inc_err = accept & cmd_err;

   always_ff @(posedge nice_clk or posedge rst) begin
      if (rst) begin
         stat_rd_cnt  <= '0;
         stat_wr_cnt  <= '0;
         stat_err_cnt <= '0;
      end else if (stat_clr) begin
         stat_rd_cnt  <= '0;
         stat_wr_cnt  <= '0;
         stat_err_cnt <= '0;
      end else begin
         if (inc_rd  && stat_rd_cnt  != 16'hFFFF) stat_rd_cnt  <= stat_rd_cnt  + 16'd1;
         if (inc_wr  && stat_wr_cnt  != 16'hFFFF) stat_wr_cnt  <= stat_wr_cnt  + 16'd1;
         if (inc_err && stat_err_cnt != 16'hFFFF) stat_err_cnt <= stat_err_cnt + 16'd1;
      end
   end
`endif

endmodule
